// File: rtl/rv32i_writeback.sv
// Writeback stage of the rv32i pipeline: retires ALU results and formatted loads
// into the integer register file, stalls upstream while a load is outstanding.
module rv32i_writeback #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_in,
   input  logic             flush,
   input  logic [4:0]       in_rd,
   input  logic             in_wr_rd,
   input  logic [XLEN-1:0]  in_result,
   input  logic             in_is_load,
   input  logic [2:0]       in_funct3,
   input  logic             mem_ack,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic [4:0]       rd,
   output logic [XLEN-1:0]  rd_wdata,
   output logic             w_en,
   output logic             stall,
   output logic             misaligned,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic {IDLE, WAIT_LOAD} state_t;

   state_t           state, state_n;
   logic [4:0]       ld_rd, ld_rd_n;
   logic             ld_wr, ld_wr_n;
   logic [2:0]       ld_funct3, ld_funct3_n;
   logic [1:0]       ld_off, ld_off_n;
   logic [4:0]       rd_n;
   logic [XLEN-1:0]  rd_wdata_n;
   logic             w_en_n;
   logic             misaligned_n;
   logic [CNT_W-1:0] instret_n;

   // Illegal funct3 codes fall into the same trap as misaligned accesses.
   function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         3'b000, 3'b100: load_bad = 1'b0;
         3'b001, 3'b101: load_bad = off[0];
         3'b010:         load_bad = (off != 2'b00);
         default:        load_bad = 1'b1;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  load_format = {{(XLEN-8){b[7]}}, b};
         3'b100:  load_format = {{(XLEN-8){1'b0}}, b};
         3'b001:  load_format = {{(XLEN-16){h[15]}}, h};
         3'b101:  load_format = {{(XLEN-16){1'b0}}, h};
         default: load_format = word;
      endcase
   endfunction

   assign stall = (state == WAIT_LOAD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ld_rd      <= '0;
         ld_wr      <= 1'b0;
         ld_funct3  <= '0;
         ld_off     <= '0;
         rd         <= '0;
         rd_wdata   <= '0;
         w_en       <= 1'b0;
         misaligned <= 1'b0;
         instret    <= '0;
      end else begin
         state      <= state_n;
         ld_rd      <= ld_rd_n;
         ld_wr      <= ld_wr_n;
         ld_funct3  <= ld_funct3_n;
         ld_off     <= ld_off_n;
         rd         <= rd_n;
         rd_wdata   <= rd_wdata_n;
         w_en       <= w_en_n;
         misaligned <= misaligned_n;
         instret    <= instret_n;
      end
   end

   always_comb begin
      state_n      = state;
      ld_rd_n      = ld_rd;
      ld_wr_n      = ld_wr;
      ld_funct3_n  = ld_funct3;
      ld_off_n     = ld_off;
      rd_n         = rd;
      rd_wdata_n   = rd_wdata;
      w_en_n       = 1'b0;
      misaligned_n = 1'b0;
      instret_n    = instret;
      case (state)
         IDLE: begin
            if (!flush && ce_in) begin
               if (!in_is_load) begin
                  w_en_n    = in_wr_rd && (in_rd != 5'd0);
                  instret_n = instret + CNT_W'(1);
                  if (w_en_n) begin
                     rd_n       = in_rd;
                     rd_wdata_n = in_result;
                  end
               end else if (load_bad(in_funct3, in_result[1:0])) begin
                  misaligned_n = 1'b1;
               end else begin
                  ld_rd_n     = in_rd;
                  ld_wr_n     = in_wr_rd;
                  ld_funct3_n = in_funct3;
                  ld_off_n    = in_result[1:0];
                  state_n     = WAIT_LOAD;
               end
            end
         end
         WAIT_LOAD: begin
            // flush wins over a same-cycle response; the load is simply dropped
            if (flush) begin
               state_n = IDLE;
            end else if (mem_ack) begin
               state_n   = IDLE;
               w_en_n    = ld_wr && (ld_rd != 5'd0);
               instret_n = instret + CNT_W'(1);
               if (w_en_n) begin
                  rd_n       = ld_rd;
                  rd_wdata_n = load_format(ld_funct3, ld_off, mem_rdata);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed self-checking bench for rv32i_writeback: reset, ALU retire, load
// formatting, delayed ack, misalignment and flush.
module tb_rv32i_writeback;

   logic        clk = 1'b0;
   logic        rst, ce_in, flush, in_wr_rd, in_is_load, mem_ack;
   logic [4:0]  in_rd;
   logic [31:0] in_result, mem_rdata;
   logic [2:0]  in_funct3;
   logic [4:0]  rd;
   logic [31:0] rd_wdata;
   logic        w_en, stall, misaligned;
   logic [31:0] instret;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_ret = 0;

   always #5 clk = ~clk;

   rv32i_writeback #(.XLEN(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .ce_in(ce_in), .flush(flush), .in_rd(in_rd),
      .in_wr_rd(in_wr_rd), .in_result(in_result), .in_is_load(in_is_load),
      .in_funct3(in_funct3), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rd(rd), .rd_wdata(rd_wdata), .w_en(w_en), .stall(stall),
      .misaligned(misaligned), .instret(instret)
   );

   always @(posedge clk)
      if (!rst && ce_in && stall) begin
         bad++;
         $display("FAIL protocol: ce_in=1 while stall=1 at %0t", $time);
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic load, input logic [2:0] f3, input logic [4:0] r,
                        input logic wr, input logic [31:0] res);
      ce_in = 1'b1; in_is_load = load; in_funct3 = f3; in_rd = r; in_wr_rd = wr; in_result = res;
      tick();
      ce_in = 1'b0; in_is_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      total++; if (rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rd); end
      total++; if (rd_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rd_wdata); end
      total++; if ({w_en, stall, misaligned} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {w_en, stall, misaligned}); end
      total++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret); end
      rst = 1'b0;
      issue(1'b1, 3'b010, 5'd3, 1'b1, 32'h100);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL rstload_stall got=%b exp=1", stall); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if ({stall, w_en} !== 2'b00) begin bad++; $display("FAIL rstload_flags got=%b exp=00", {stall, w_en}); end
      total++; if (instret !== 32'd0) begin bad++; $display("FAIL rstload_instret got=%0d exp=0", instret); end
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_ack = 1'b0;
      total++; if (w_en !== 1'b0) begin bad++; $display("FAIL rstload_lateack got=%b exp=0", w_en); end
   endtask

   task automatic test_alu();
      issue(1'b0, 3'b000, 5'd5, 1'b1, 32'hDEADBEEF);
      exp_ret++;
      total++; if (w_en !== 1'b1) begin bad++; $display("FAIL alu_wen got=%b exp=1", w_en); end
      total++; if (rd !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d exp=5", rd); end
      total++; if (rd_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_wdata got=%h exp=deadbeef", rd_wdata); end
      total++; if (instret !== exp_ret) begin bad++; $display("FAIL alu_instret got=%0d exp=%0d", instret, exp_ret); end
      tick();
      total++; if (w_en !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%b exp=0", w_en); end
      issue(1'b0, 3'b000, 5'd0, 1'b1, 32'h12345678);
      exp_ret++;
      total++; if (w_en !== 1'b0) begin bad++; $display("FAIL alu_x0_wen got=%b exp=0", w_en); end
      total++; if (instret !== exp_ret) begin bad++; $display("FAIL alu_x0_instret got=%0d exp=%0d", instret, exp_ret); end
      total++; if (rd_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_x0_hold got=%h exp=deadbeef", rd_wdata); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3 [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
      logic [1:0]  of [7] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
      logic [31:0] ex [7] = '{32'hFFFFFF82, 32'h00000080, 32'hFFFF80F1, 32'h00007F82,
                              32'h80F17F82, 32'h0000007F, 32'h00007F82};
      mem_rdata = 32'h80F17F82;
      for (int i = 0; i < 7; i++) begin
         issue(1'b1, f3[i], 5'(10 + i), 1'b1, 32'h0000_2000 | 32'(of[i]));
         total++; if ({stall, w_en} !== 2'b10) begin bad++; $display("FAIL load%0d_wait got=%b exp=10", i, {stall, w_en}); end
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
         exp_ret++;
         total++; if ({w_en, stall} !== 2'b10) begin bad++; $display("FAIL load%0d_flags got=%b exp=10", i, {w_en, stall}); end
         total++; if (rd_wdata !== ex[i]) begin bad++; $display("FAIL load%0d_data got=%h exp=%h", i, rd_wdata, ex[i]); end
         total++; if (rd !== 5'(10 + i)) begin bad++; $display("FAIL load%0d_rd got=%0d exp=%0d", i, rd, 10 + i); end
         total++; if (instret !== exp_ret) begin bad++; $display("FAIL load%0d_instret got=%0d exp=%0d", i, instret, exp_ret); end
      end
   endtask

   task automatic test_delayed_ack();
      mem_rdata = 32'h12345678;
      issue(1'b1, 3'b010, 5'd7, 1'b1, 32'h3000);
      for (int i = 0; i < 4; i++) begin
         total++; if ({stall, w_en} !== 2'b10) begin bad++; $display("FAIL delay_wait%0d got=%b exp=10", i, {stall, w_en}); end
         if (i == 3) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      exp_ret++;
      total++; if ({w_en, stall} !== 2'b10) begin bad++; $display("FAIL delay_flags got=%b exp=10", {w_en, stall}); end
      total++; if (rd_wdata !== 32'h12345678) begin bad++; $display("FAIL delay_data got=%h exp=12345678", rd_wdata); end
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      tick();
      mem_ack = 1'b0;
      total++; if ({w_en, stall} !== 2'b00) begin bad++; $display("FAIL delay_stray got=%b exp=00", {w_en, stall}); end
      total++; if (instret !== exp_ret) begin bad++; $display("FAIL delay_instret got=%0d exp=%0d", instret, exp_ret); end
   endtask

   task automatic test_misaligned();
      logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
      logic [31:0] ad [3] = '{32'h4002, 32'h4001, 32'h4000};
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, f3[i], 5'd12, 1'b1, ad[i]);
         total++; if ({misaligned, stall, w_en} !== 3'b100) begin bad++; $display("FAIL mis%0d_capture got=%b exp=100", i, {misaligned, stall, w_en}); end
         total++; if (instret !== exp_ret) begin bad++; $display("FAIL mis%0d_instret got=%0d exp=%0d", i, instret, exp_ret); end
         tick();
         total++; if ({misaligned, stall, w_en} !== 3'b000) begin bad++; $display("FAIL mis%0d_after got=%b exp=000", i, {misaligned, stall, w_en}); end
      end
   endtask

   task automatic test_flush();
      issue(1'b1, 3'b010, 5'd8, 1'b1, 32'h5000);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_stall got=%b exp=1", stall); end
      flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
      tick();
      flush = 1'b0; mem_ack = 1'b0;
      total++; if ({w_en, stall} !== 2'b00) begin bad++; $display("FAIL flush_flags got=%b exp=00", {w_en, stall}); end
      total++; if (instret !== exp_ret) begin bad++; $display("FAIL flush_instret got=%0d exp=%0d", instret, exp_ret); end
      issue(1'b0, 3'b000, 5'd9, 1'b1, 32'h00000055);
      exp_ret++;
      total++; if ({w_en, rd, rd_wdata} !== {1'b1, 5'd9, 32'h55}) begin bad++; $display("FAIL flush_next got=%b/%0d/%h exp=1/9/55", w_en, rd, rd_wdata); end
      total++; if (instret !== exp_ret) begin bad++; $display("FAIL flush_next_instret got=%0d exp=%0d", instret, exp_ret); end
      flush = 1'b1;
      issue(1'b0, 3'b000, 5'd4, 1'b1, 32'h77);
      flush = 1'b0;
      total++; if ({w_en, stall} !== 2'b00) begin bad++; $display("FAIL flush_idle got=%b exp=00", {w_en, stall}); end
      total++; if (instret !== exp_ret) begin bad++; $display("FAIL flush_idle_instret got=%0d exp=%0d", instret, exp_ret); end
   endtask

   initial begin
      rst = 1'b1; ce_in = 1'b0; flush = 1'b0; in_wr_rd = 1'b0; in_is_load = 1'b0;
      mem_ack = 1'b0; in_rd = '0; in_result = '0; mem_rdata = '0; in_funct3 = '0;
      #2;
      test_reset();
      test_alu();
      test_loads();
      test_delayed_ack();
      test_misaligned();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv32i_writeback.md
Name: rv32i_writeback

Overview:
- Stage 5 (Writeback) of the rv32i pipeline; the write side of the 32-entry integer register file.
- Captures retiring instructions from Stage 4 (Memory).
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the returned word.
- Drives the register-file write port (rd, rd_wdata, w_en) registered, one cycle after the result is known; also stalls upstream and counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- ce_in  input  1  Stage 4 valid/clock-enable; one instruction per high cycle.
- flush  input  1  discard any pending load; highest priority after rst.
- in_rd  input  5  destination register of the incoming instruction.
- in_wr_rd  input  1  instruction writes rd.
- in_result  input  32  ALU/CSR result, or load address for loads.
- in_is_load  input  1  instruction is a load.
- in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other values are illegal.
- mem_ack  input  1  data-memory read response valid.
- mem_rdata  input  32  data-memory read word, word-aligned.
- rd  output  5  register-file write address.
- rd_wdata  output  32  register-file write data.
- w_en  output  1  register-file write enable.
- stall  output  1  upstream must hold; Stage 4 must not assert ce_in while high.
- misaligned  output  1  one-cycle pulse on a misaligned load.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset: rd=0, rd_wdata=0, w_en=0, stall=0, misaligned=0, instret=0, state=IDLE. Any pending load is dropped.
- States: IDLE and WAIT_LOAD.
- IDLE, ce_in=1, in_is_load=0:
  - Next cycle: w_en = in_wr_rd && (in_rd != 0); rd = in_rd; rd_wdata = in_result.
  - instret increments. Latency is 1 cycle.
- IDLE, ce_in=1, in_is_load=1:
  - Latch rd, wr_rd, funct3 and in_result[1:0]; go to WAIT_LOAD; stall=1 from the next cycle.
- WAIT_LOAD, mem_ack=1:
  - Next cycle: w_en as above; rd_wdata = formatted data; instret increments.
  - State returns to IDLE and stall=0 in that same cycle.
- WAIT_LOAD, mem_ack=0: hold state; w_en=0.
- Load formatting, with offset o = latched addr[1:0]:
  - LB/LBU: byte mem_rdata[8*o+7:8*o], sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: halfword at o (0 or 2), sign-/zero-extended.
  - LW: the full word.
- Misalignment:
  - Misaligned means LH/LHU with o[0]=1, or LW with o!=0.
  - Detected at capture time: no WAIT_LOAD, no write, no instret increment.
  - misaligned=1 for exactly one cycle, the cycle after capture.
  - An illegal funct3 is treated the same way.
- w_en is a one-cycle pulse per retirement; it is never high two cycles in a row for one instruction.
- Writes to x0 are suppressed (w_en=0), but the instruction still counts in instret.
- Ignored inputs:
  - mem_ack while IDLE is ignored.
  - ce_in while WAIT_LOAD is ignored; this is a protocol violation, and the bench asserts it never occurs.
- flush:
  - In WAIT_LOAD: return to IDLE, stall=0 next cycle, no write, no increment. A same-cycle mem_ack is dropped.
  - In IDLE with ce_in=1: the instruction is discarded.
- instret wraps modulo 2^CNT_W.
- rd and rd_wdata hold their last values when w_en=0.

Test Plan:
- Reset mid-load: capture LW, then rst=1 before mem_ack. Next cycle: stall=0, w_en=0, instret=0; a later mem_ack produces no write.
- ALU retire: ce_in=1, in_rd=5, in_result=0xDEADBEEF, in_wr_rd=1. Next cycle: w_en=1, rd=5, rd_wdata=0xDEADBEEF, instret=1. With in_rd=0: w_en=0, instret still increments.
- Loads with mem_rdata=0x80F1_7F82:
  - LB o=0 -> 0xFFFFFF82.
  - LBU o=3 -> 0x00000080.
  - LH o=2 -> 0xFFFF80F1.
  - LHU o=0 -> 0x00007F82.
  - LW o=0 -> 0x80F17F82.
  - Each write occurs 1 cycle after mem_ack; stall is high for every cycle of WAIT_LOAD.
- Delayed ack: LW with mem_ack arriving 4 cycles after capture. stall is high for exactly those 4 cycles, then one w_en pulse; a stray mem_ack afterwards is ignored.
- Misaligned: LW with addr[1:0]=2, and LH with addr[1:0]=1. Each gives misaligned=1 for one cycle, w_en=0, stall never asserted, instret unchanged.
- Flush: LW captured, then flush and mem_ack asserted in the same cycle. No write; IDLE and stall=0 next cycle; the next ALU instruction retires normally.
